// File: rtl/verisparse.sv
// Shared types and default sizes for the sparse-recovery datapath.
package verisparse;

  localparam int unsigned SIGNAL_SIZE_DEFAULT       = 64;
  localparam int unsigned DICTIONARY_SIZE_DEFAULT   = 256;
  localparam int unsigned CORR_ACC_WIDTH_DEFAULT    = 32;
  localparam int unsigned DATA_BUS_WIDTH            = 8;
  localparam int unsigned SIGNAL_ADDR_WIDTH         = $clog2(SIGNAL_SIZE_DEFAULT);
  localparam int unsigned DICTIONARY_ADDR_WIDTH     = $clog2(SIGNAL_SIZE_DEFAULT * DICTIONARY_SIZE_DEFAULT);
  localparam int unsigned REPRESENTATION_ADDR_WIDTH = $clog2(DICTIONARY_SIZE_DEFAULT);

  typedef enum logic [2:0] {
    CORR_IDLE,
    CORR_READ,
    CORR_DRAIN,
    CORR_CMP,
    CORR_DONE
  } corr_state_t;

endpackage

// File: rtl/pursuit_correlate_ctrl_if.sv
// Read bus towards the residual (y) and dictionary memories.
interface pursuit_correlate_ctrl_if;
  import verisparse::*;

  logic        [SIGNAL_ADDR_WIDTH-1:0]     y_read_addr;
  logic signed [DATA_BUS_WIDTH-1:0]        y_read_data;
  logic        [DICTIONARY_ADDR_WIDTH-1:0] dict_read_addr;
  logic signed [DATA_BUS_WIDTH-1:0]        dict_read_data;

  modport master (
    output y_read_addr,
    output dict_read_addr,
    input  y_read_data,
    input  dict_read_data
  );

  modport slave (
    input  y_read_addr,
    input  dict_read_addr,
    output y_read_data,
    output dict_read_data
  );

endinterface

// File: rtl/pursuit_mac.sv
// Signed 8x8 multiply-accumulate with synchronous clear and enable.
module pursuit_mac
  import verisparse::*;
#(
  parameter int unsigned ACC_WIDTH = CORR_ACC_WIDTH_DEFAULT
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             i_clear,
  input  logic                             i_en,
  input  logic signed [DATA_BUS_WIDTH-1:0] i_a,
  input  logic signed [DATA_BUS_WIDTH-1:0] i_b,
  output logic signed [ACC_WIDTH-1:0]      o_acc
);

  localparam int unsigned PROD_WIDTH = 2 * DATA_BUS_WIDTH;

  logic signed [PROD_WIDTH-1:0] w_prod;
  logic signed [ACC_WIDTH-1:0]  w_prod_ext;
  logic signed [ACC_WIDTH-1:0]  r_acc;

  assign w_prod     = i_a * i_b;
  assign w_prod_ext = {{(ACC_WIDTH - PROD_WIDTH){w_prod[PROD_WIDTH-1]}}, w_prod};

  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= r_acc + w_prod_ext;
    end
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/pursuit_correlate_ctrl.sv
// Matching-pursuit atom selection: correlates every atom with y and keeps the largest |corr|.
// Optional atom exclusion via support bitmap under VERISPARSE_CORR_EXCLUDE_EN.
module pursuit_correlate_ctrl
  import verisparse::*;
#(
  parameter int unsigned SIGNAL_SIZE     = SIGNAL_SIZE_DEFAULT,
  parameter int unsigned DICTIONARY_SIZE = DICTIONARY_SIZE_DEFAULT,
  parameter int unsigned ACC_WIDTH       = CORR_ACC_WIDTH_DEFAULT
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 start,
`ifdef VERISPARSE_CORR_EXCLUDE_EN
  input  logic                                 clear_support,
`endif
  output logic                                 busy,
  output logic                                 done,
  output logic                                 found,
  output logic [REPRESENTATION_ADDR_WIDTH-1:0] best_index,
  output logic signed [ACC_WIDTH-1:0]          best_corr,
  pursuit_correlate_ctrl_if.master             bus
);

  localparam logic [SIGNAL_ADDR_WIDTH-1:0] M_LAST =
    SIGNAL_ADDR_WIDTH'(SIGNAL_SIZE - 1);
  localparam logic [REPRESENTATION_ADDR_WIDTH-1:0] N_LAST =
    REPRESENTATION_ADDR_WIDTH'(DICTIONARY_SIZE - 1);

  corr_state_t                          r_state;
  logic [SIGNAL_ADDR_WIDTH-1:0]         r_m;
  logic [REPRESENTATION_ADDR_WIDTH-1:0] r_n;
  logic [DICTIONARY_ADDR_WIDTH-1:0]     r_dict_addr;
  logic                                 r_have_best;
  logic                                 r_busy;
  logic                                 r_done;
  logic                                 r_found;
  logic [REPRESENTATION_ADDR_WIDTH-1:0] r_best_index;
  logic signed [ACC_WIDTH-1:0]          r_best_corr;

  logic signed [ACC_WIDTH-1:0] w_acc;
  logic [ACC_WIDTH-1:0]        w_acc_mag;
  logic [ACC_WIDTH-1:0]        w_best_mag;
  logic                        w_mac_en;
  logic                        w_mac_clr;
  logic                        w_eligible;
  logic                        w_take;

  // The first READ cycle returns data for the IDLE address, so it is skipped.
  assign w_mac_en  = ((r_state == CORR_READ) && (r_m != '0)) || (r_state == CORR_DRAIN);
  assign w_mac_clr = (r_state == CORR_IDLE) || (r_state == CORR_CMP);

  pursuit_mac #(
    .ACC_WIDTH (ACC_WIDTH)
  ) u_mac (
    .clk     (clk),
    .reset   (reset),
    .i_clear (w_mac_clr),
    .i_en    (w_mac_en),
    .i_a     (bus.y_read_data),
    .i_b     (bus.dict_read_data),
    .o_acc   (w_acc)
  );

  assign w_acc_mag  = w_acc[ACC_WIDTH-1] ? -w_acc : w_acc;
  assign w_best_mag = r_best_corr[ACC_WIDTH-1] ? -r_best_corr : r_best_corr;

`ifdef VERISPARSE_CORR_EXCLUDE_EN
  localparam int unsigned IDX_W = $clog2(DICTIONARY_SIZE);
  logic [DICTIONARY_SIZE-1:0] r_support;
  assign w_eligible = !r_support[r_n[IDX_W-1:0]];
`else
  assign w_eligible = 1'b1;
`endif

  // Strict compare keeps the lowest index on equal magnitude.
  assign w_take = w_eligible && (!r_have_best || (w_acc_mag > w_best_mag));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= CORR_IDLE;
      r_m          <= '0;
      r_n          <= '0;
      r_dict_addr  <= '0;
      r_have_best  <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_found      <= 1'b0;
      r_best_index <= '0;
      r_best_corr  <= '0;
`ifdef VERISPARSE_CORR_EXCLUDE_EN
      r_support    <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        CORR_IDLE: begin
`ifdef VERISPARSE_CORR_EXCLUDE_EN
          if (clear_support) r_support <= '0;
`endif
          if (start) begin
            r_state     <= CORR_READ;
            r_busy      <= 1'b1;
            r_m         <= '0;
            r_n         <= '0;
            r_dict_addr <= '0;
            r_have_best <= 1'b0;
          end
        end
        CORR_READ: begin
          if (r_m == M_LAST) begin
            r_state <= CORR_DRAIN;
          end else begin
            r_m         <= r_m + 1'b1;
            r_dict_addr <= r_dict_addr + 1'b1;
          end
        end
        CORR_DRAIN: r_state <= CORR_CMP;
        CORR_CMP: begin
          if (w_take) begin
            r_best_corr  <= w_acc;
            r_best_index <= r_n;
            r_have_best  <= 1'b1;
            r_found      <= 1'b1;
          end else if (!r_have_best) begin
            r_best_corr  <= '0;
            r_best_index <= '0;
            r_found      <= 1'b0;
          end
          if (r_n == N_LAST) begin
            r_state <= CORR_DONE;
            r_done  <= 1'b1;
          end else begin
            r_n         <= r_n + 1'b1;
            r_m         <= '0;
            r_dict_addr <= r_dict_addr + 1'b1;
            r_state     <= CORR_READ;
          end
        end
        CORR_DONE: begin
`ifdef VERISPARSE_CORR_EXCLUDE_EN
          if (r_found) r_support[r_best_index[IDX_W-1:0]] <= 1'b1;
`endif
          r_state     <= CORR_IDLE;
          r_busy      <= 1'b0;
          r_m         <= '0;
          r_dict_addr <= '0;
        end
        default: r_state <= CORR_IDLE;
      endcase
    end
  end

  assign busy               = r_busy;
  assign done               = r_done;
  assign found              = r_found;
  assign best_index         = r_best_index;
  assign best_corr          = r_best_corr;
  assign bus.y_read_addr    = r_m;
  assign bus.dict_read_addr = r_dict_addr;

endmodule

// File: tb/tb_pursuit_correlate_ctrl.sv
// Scoreboard bench for pursuit_correlate_ctrl with M=4, N=8 and single-cycle memory models.
module tb_pursuit_correlate_ctrl;
  import verisparse::*;

  localparam int unsigned M  = 4;
  localparam int unsigned N  = 8;
  localparam int unsigned AW = 32;
  localparam int DONE_CYC    = N * (M + 2) + 1;

  logic clk = 1'b0;
  logic reset;
  logic start;
`ifdef VERISPARSE_CORR_EXCLUDE_EN
  logic clear_support;
  logic [N-1:0] m_support;
`endif
  logic busy, done, found;
  logic [REPRESENTATION_ADDR_WIDTH-1:0] best_index;
  logic signed [AW-1:0] best_corr;

  pursuit_correlate_ctrl_if bus ();

  pursuit_correlate_ctrl #(
    .SIGNAL_SIZE     (M),
    .DICTIONARY_SIZE (N),
    .ACC_WIDTH       (AW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
`ifdef VERISPARSE_CORR_EXCLUDE_EN
    .clear_support (clear_support),
`endif
    .busy          (busy),
    .done          (done),
    .found         (found),
    .best_index    (best_index),
    .best_corr     (best_corr),
    .bus           (bus)
  );

  always #5 clk = ~clk;

  logic signed [7:0] y_mem    [M];
  logic signed [7:0] dict_mem [N*M];

  always @(posedge clk) begin
    bus.y_read_data    <= y_mem[bus.y_read_addr[1:0]];
    bus.dict_read_data <= dict_mem[bus.dict_read_addr[4:0]];
  end

  typedef struct {
    longint idx;
    longint corr;
    longint fnd;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic longint labs(input longint v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic exp_t model();
    exp_t   e;
    bit     have = 0;
    longint s;
    e.idx = 0; e.corr = 0; e.fnd = 0;
    for (int n = 0; n < int'(N); n++) begin
`ifdef VERISPARSE_CORR_EXCLUDE_EN
      if (m_support[n]) continue;
`endif
      s = 0;
      for (int m = 0; m < int'(M); m++)
        s += longint'(y_mem[m]) * longint'(dict_mem[n*M+m]);
      if (!have || labs(s) > labs(e.corr)) begin
        have = 1; e.idx = n; e.corr = s; e.fnd = 1;
      end
    end
    return e;
  endfunction

  task automatic clear_dict();
    for (int i = 0; i < int'(N*M); i++) dict_mem[i] = 8'sd0;
  endtask

  task automatic load_vec1();
    for (int m = 0; m < int'(M); m++) y_mem[m] = 8'(m + 1);
    clear_dict();
    for (int m = 0; m < int'(M); m++) dict_mem[5*M+m] = 8'(M - m);
  endtask

  task automatic load_vec2();
    for (int m = 0; m < int'(M); m++) y_mem[m] = 8'(m + 1);
    clear_dict();
    for (int m = 0; m < int'(M); m++) begin
      dict_mem[2*M+m] = 8'(-2 * (m + 1));
      dict_mem[6*M+m] = 8'(2 * (m + 1));
    end
  endtask

  task automatic load_vec3();
    for (int m = 0; m < int'(M); m++) y_mem[m] = -8'sd128;
    clear_dict();
    for (int m = 0; m < int'(M); m++) dict_mem[3*M+m] = -8'sd128;
  endtask

  task automatic load_random();
    for (int m = 0; m < int'(M); m++) y_mem[m] = 8'($urandom_range(255, 0));
    for (int i = 0; i < int'(N*M); i++) dict_mem[i] = 8'($urandom_range(255, 0));
  endtask

  // Called right after a negedge; returns right after a negedge.
  task automatic run_pass(input string tag, input bit poke_busy);
    exp_t e;
    int   cyc;
    int   extra;
    e = model();
    sb.push_back(e);
`ifdef VERISPARSE_CORR_EXCLUDE_EN
    if (e.fnd != 0) m_support[int'(e.idx)] = 1'b1;
`endif
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    chk({tag, "_busy_first"}, longint'(busy), 1);
    while (!done && cyc < 200) begin
      start = poke_busy && (cyc == 10 || cyc == 30);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    chk({tag, "_done_cycle"}, cyc, DONE_CYC);
    chk({tag, "_busy_at_done"}, longint'(busy), 1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, "_best_index"}, longint'(best_index), e.idx);
      chk({tag, "_best_corr"}, longint'(best_corr), e.corr);
      chk({tag, "_found"}, longint'(found), e.fnd);
    end
    @(negedge clk);
    chk({tag, "_idle_busy"}, longint'(busy), 0);
    chk({tag, "_done_pulse"}, longint'(done), 0);
    if (poke_busy) begin
      extra = 0;
      for (int i = 0; i < 60; i++) begin
        @(negedge clk);
        if (done) extra++;
      end
      chk({tag, "_extra_done"}, extra, 0);
    end
  endtask

`ifdef VERISPARSE_CORR_EXCLUDE_EN
  task automatic pulse_clear();
    clear_support = 1'b1;
    @(negedge clk);
    clear_support = 1'b0;
    m_support = '0;
  endtask
`endif

  initial begin
    int dones;
    reset = 1'b1;
    start = 1'b0;
`ifdef VERISPARSE_CORR_EXCLUDE_EN
    clear_support = 1'b0;
    m_support     = '0;
`endif
    load_vec1();
    repeat (3) @(negedge clk);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_done", longint'(done), 0);
    chk("rst_found", longint'(found), 0);
    chk("rst_best_index", longint'(best_index), 0);
    chk("rst_best_corr", longint'(best_corr), 0);
    chk("rst_y_addr", longint'(bus.y_read_addr), 0);
    chk("rst_dict_addr", longint'(bus.dict_read_addr), 0);
    reset = 1'b0;
    @(negedge clk);

    run_pass("vec1", 1'b0);
    chk("vec1_idle_y_addr", longint'(bus.y_read_addr), 0);
    chk("vec1_idle_dict_addr", longint'(bus.dict_read_addr), 0);

`ifdef VERISPARSE_CORR_EXCLUDE_EN
    run_pass("excl_second", 1'b0);
    for (int p = 3; p <= 9; p++) run_pass($sformatf("excl_pass%0d", p), 1'b0);
    chk("excl_all_found", longint'(found), 0);
    pulse_clear();
    run_pass("excl_cleared", 1'b0);
    chk("excl_cleared_index", longint'(best_index), 5);
    pulse_clear();
`endif

    load_vec2();
    run_pass("tie", 1'b0);
    load_vec3();
    run_pass("maxneg", 1'b0);

    // Abort a pass with reset at cycle 20.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c < 20; c++) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
`ifdef VERISPARSE_CORR_EXCLUDE_EN
    m_support = '0;
`endif
    chk("abort_busy", longint'(busy), 0);
    chk("abort_done", longint'(done), 0);
    chk("abort_found", longint'(found), 0);
    chk("abort_best_index", longint'(best_index), 0);
    chk("abort_best_corr", longint'(best_corr), 0);
    chk("abort_y_addr", longint'(bus.y_read_addr), 0);
    chk("abort_dict_addr", longint'(bus.dict_read_addr), 0);
    dones = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done || busy) dones++;
    end
    chk("abort_no_done", dones, 0);
    run_pass("after_abort", 1'b0);

    load_random();
    run_pass("poke_busy", 1'b1);
    for (int r = 0; r < 4; r++) begin
      load_random();
      run_pass($sformatf("rand%0d", r), 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pursuit_correlate_ctrl.md
# pursuit_correlate_ctrl

Sequencer for the matching-pursuit atom-selection step: it walks every dictionary atom, streams the signal (residual) and atom samples over the y and dict read buses, and accumulates their signed inner product. It tracks the atom with the largest correlation magnitude and reports it. It sits between the pursuit top-level controller (start/done) and the y/dict memories of `pursuit_bus_t`.

## Interface
- `SIGNAL_SIZE`, default `SIGNAL_SIZE_DEFAULT` (64): samples per signal/atom, M.
- `DICTIONARY_SIZE`, default `DICTIONARY_SIZE_DEFAULT` (256): number of atoms, N.
- `ACC_WIDTH`, default 32: accumulator width. Must be ≥ 16 + clog2(M) + 1.
- `clk`  in  1  clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  begin one selection pass; sampled only in IDLE.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse; result ports valid from this cycle.
- `found`  out  1  at least one eligible atom was evaluated in the last pass.
- `y_read_addr`  out  `SIGNAL_ADDR_WIDTH`  sample index m.
- `y_read_data`  in  `DATA_BUS_WIDTH`  signed sample, 1-cycle read latency.
- `dict_read_addr`  out  `DICTIONARY_ADDR_WIDTH`  n*M + m (column-major atoms).
- `dict_read_data`  in  `DATA_BUS_WIDTH`  signed atom sample, 1-cycle read latency.
- `best_index`  out  `REPRESENTATION_ADDR_WIDTH`  winning atom index.
- `best_corr`  out  `ACC_WIDTH`  signed inner product of the winner.

## Operation
- Reset: state IDLE; all outputs 0; accumulator, counters and best-tracking registers cleared.
- FSM states are IDLE, READ, DRAIN, CMP and DONE.
- IDLE → READ on `start`. Atom counter n=0, sample counter m=0, accumulator 0, no best held.
- READ: present addresses m and n*M+m. Each cycle, accumulate the product of the data returned for the previous address. After m=M-1, go to DRAIN.
- DRAIN: accumulate the final product. Addresses hold their last value. Go to CMP.
- CMP: the current atom becomes best if no best is held yet, or if |acc| > |best_corr| (strict, so the lowest index wins ties). Then clear the accumulator. If n=N-1, go to DONE; otherwise increment n, set m=0 and go to READ.
- DONE: `done`=1 for one cycle, then IDLE. `best_index`, `best_corr` and `found` hold until the next pass reaches CMP.
- Arithmetic: 8×8 signed product (16 bit), sign-extended to `ACC_WIDTH`, wrapping add. Magnitude is taken as `ACC_WIDTH`-bit unsigned; the width rule guarantees no overflow.
- Addresses are 0 in IDLE.
- `start` is ignored while `busy`.
- Reset mid-pass aborts to IDLE with the reset values; no `done`.

## Timing
- If `start` is sampled at cycle 0: READ covers cycles 1..M, DRAIN is M+1, CMP is M+2. Atom k's CMP falls at (k+1)(M+2).
- `done` is at cycle N(M+2)+1. `busy` is high for cycles 1..N(M+2)+1.
- A new `start` is accepted in the first cycle back in IDLE (N(M+2)+2).

## Configuration
- Macro: `VERISPARSE_CORR_EXCLUDE_EN`.
- Defined:
  - Adds input `clear_support` (1 bit) and an internal N-bit support bitmap.
  - In CMP, atoms whose bit is set are not eligible.
  - In DONE, if `found`, set the bit at `best_index`.
  - `clear_support` zeroes the bitmap when sampled in IDLE; it is ignored while busy. Reset also zeroes the bitmap.
  - If no atom is eligible: `found`=0, `best_index`=0, `best_corr`=0.
- Undefined: no port and no bitmap. Every atom is eligible; `found`=1 at every `done`.

## Structure
- Add to package `verisparse`: the state enum `corr_state_t`, and `CORR_ACC_WIDTH_DEFAULT` = 32.
- Sub-module `pursuit_mac`: signed 8×8 multiply-accumulate with synchronous clear and enable, `ACC_WIDTH` parameter.

## Test plan
Benches use M=4, N=8 and single-cycle memory models.
- y={1,2,3,4}; atom 5={4,3,2,1}; other atoms all 0 → `done` at cycle 49, `best_index`=5, `best_corr`=20, `found`=1.
- Atom 2 = y·(−2), atom 6 = y·(+2) → `best_index`=2, `best_corr`=−60 (tie on magnitude; lower index wins).
- y and atom 3 all −128 → `best_corr`=65536; no wrap.
- `reset` at cycle 20 of a pass → next cycle: `busy`=0, addresses 0, results 0; no `done`. A new `start` then completes normally.
- `start` pulsed while busy → ignored; exactly one `done`.
- With `VERISPARSE_CORR_EXCLUDE_EN`:
  - Two passes on the first vector → second pass picks the next-best atom.
  - After 8 passes without `clear_support`, the ninth pass gives `found`=0, `best_index`=0, `best_corr`=0.
  - After `clear_support`, the winner is 5 again.
